// File: rtl/u_dmem.sv
// u_dmem: data-side SRAM responder with byte lanes, 1-cycle read latency and unmapped-access flag.
// Define DMEM_MMIO_EN to decode cyc_cnt/tohost/scratch registers at bytes 0xFF00-0xFF0F ahead of the array.
module u_dmem #(
  parameter int DEPTH = 4096,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] dat_a,
  input  logic [3:0]    dat_we,
  input  logic [31:0]   dat_wd,
  input  logic [3:0]    dat_re,
  output logic [31:0]   dat_rd,
  output logic          err,
  output logic          halt,
  output logic [31:0]   tohost
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = AW - 2;

  function automatic logic [31:0] lane_expand(input logic [3:0] en);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{en[i]}};
    return m;
  endfunction

  logic [WW-1:0] word_idx;
  logic [IW-1:0] mem_addr;
  logic          is_wr;
  logic          is_rd;
  logic          in_array;
  logic          array_sel;
  logic          bad_addr;
  logic          unused_bits;

  assign word_idx    = dat_a[AW-1:2];
  assign mem_addr    = word_idx[IW-1:0];
  assign is_wr       = |dat_we;
  assign is_rd       = |dat_re;
  assign in_array    = 32'(word_idx) < 32'(DEPTH);
  assign unused_bits = ^dat_a[1:0];

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_q;
  logic [3:0]  rd_mask_q;

  // Array port: output register is not reset so the RAM stays inferable;
  // the resettable lane mask below is what forces dat_rd to 0.
  always_ff @(posedge clk) begin
    if (array_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (dat_we[i]) mem[mem_addr][8*i +: 8] <= dat_wd[8*i +: 8];
      end
    end
    mem_q <= mem[mem_addr];
  end

`ifdef DMEM_MMIO_EN
  localparam logic [AW-1:0] MMIO_BASE = AW'(16'hFF00);

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] wd,
                                              input logic [3:0]  we);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  logic        mmio_hit;
  logic [1:0]  reg_sel;
  logic [31:0] cyc_cnt;
  logic [31:0] tohost_q;
  logic [31:0] scratch_q;
  logic        halt_q;
  logic [31:0] tohost_new;
  logic        tohost_wr;
  logic        scratch_wr;
  logic [31:0] reg_val;
  logic [31:0] reg_rd_q;
  logic        rd_mmio_q;

  assign mmio_hit   = (dat_a[AW-1:4] == MMIO_BASE[AW-1:4]);
  assign reg_sel    = dat_a[3:2];
  assign array_sel  = in_array && !mmio_hit;
  assign bad_addr   = mmio_hit ? (reg_sel == 2'd3) : !in_array;
  assign tohost_wr  = is_wr && mmio_hit && (reg_sel == 2'd1);
  assign scratch_wr = is_wr && mmio_hit && (reg_sel == 2'd2);
  assign tohost_new = merge_lanes(tohost_q, dat_wd, dat_we);

  always_comb begin
    reg_val = '0;
    case (reg_sel)
      2'd0:    reg_val = cyc_cnt;
      2'd1:    reg_val = tohost_q;
      2'd2:    reg_val = scratch_q;
      default: reg_val = '0;
    endcase
  end

  // halt latches on any tohost write leaving a nonzero value; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt   <= '0;
      tohost_q  <= '0;
      scratch_q <= '0;
      halt_q    <= 1'b0;
      reg_rd_q  <= '0;
      rd_mmio_q <= 1'b0;
    end else begin
      cyc_cnt   <= cyc_cnt + 32'd1;
      reg_rd_q  <= reg_val;
      rd_mmio_q <= mmio_hit;
      if (tohost_wr) begin
        tohost_q <= tohost_new;
        if (tohost_new != 32'd0) halt_q <= 1'b1;
      end
      if (scratch_wr) scratch_q <= merge_lanes(scratch_q, dat_wd, dat_we);
    end
  end

  assign halt   = halt_q;
  assign tohost = tohost_q;
  assign dat_rd = (rd_mmio_q ? reg_rd_q : mem_q) & lane_expand(rd_mask_q);
`else
  assign array_sel = in_array;
  assign bad_addr  = !in_array;
  assign halt      = 1'b0;
  assign tohost    = '0;
  assign dat_rd    = mem_q & lane_expand(rd_mask_q);
`endif

  // Lanes of a bad or absent read stay masked, so dat_rd falls to 0 on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_mask_q <= 4'b0;
      err       <= 1'b0;
    end else begin
      rd_mask_q <= (is_rd && !bad_addr) ? dat_re : 4'b0;
      err       <= (is_wr || is_rd) && bad_addr;
    end
  end

endmodule

// File: tb/tb_u_dmem.sv
// tb_u_dmem: directed self-checking bench for u_dmem (DEPTH=1024); MMIO checks build with DMEM_MMIO_EN.
module tb_u_dmem;

  logic        clk;
  logic        rst;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic        err;
  logic        halt;
  logic [31:0] tohost;

  int passed;
  int total;

  u_dmem #(.DEPTH(1024), .AW(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .dat_a  (dat_a),
    .dat_we (dat_we),
    .dat_wd (dat_wd),
    .dat_re (dat_re),
    .dat_rd (dat_rd),
    .err    (err),
    .halt   (halt),
    .tohost (tohost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for one cycle; returns 1 time unit after the edge, when its response is visible.
  task automatic drive(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re);
    dat_a  = a;
    dat_we = we;
    dat_wd = wd;
    dat_re = re;
    @(posedge clk);
    #1;
    dat_we = 4'h0;
    dat_re = 4'h0;
    dat_wd = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (dat_rd !== 32'h0) $display("[TB] FAIL reset_rd got %h exp %h", dat_rd, 32'h0); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL reset_err got %b exp 0", err); else passed++;
    total++; if (halt !== 1'b0) $display("[TB] FAIL reset_halt got %b exp 0", halt); else passed++;
    total++; if (tohost !== 32'h0) $display("[TB] FAIL reset_tohost got %h exp 0", tohost); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_full_word;
    drive(16'h0010, 4'hF, 32'hDEADBEEF, 4'h0);
    total++; if (err !== 1'b0) $display("[TB] FAIL full_wr_err got %b exp 0", err); else passed++;
    drive(16'h0010, 4'h0, 32'h0, 4'hF);
    total++; if (dat_rd !== 32'hDEADBEEF) $display("[TB] FAIL full_rd got %h exp %h", dat_rd, 32'hDEADBEEF); else passed++;
    drive(16'h0000, 4'h0, 32'h0, 4'h0);
    total++; if (dat_rd !== 32'h0) $display("[TB] FAIL idle_rd_zero got %h exp 0", dat_rd); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL idle_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_byte_lanes;
    drive(16'h0020, 4'hF, 32'h11223344, 4'h0);
    drive(16'h0020, 4'b0100, 32'h00AA0000, 4'h0);
    drive(16'h0020, 4'h0, 32'h0, 4'b0110);
    total++; if (dat_rd !== 32'h00AA3300) $display("[TB] FAIL lane_rd got %h exp %h", dat_rd, 32'h00AA3300); else passed++;
    drive(16'h0022, 4'h0, 32'h0, 4'hF);
    total++; if (dat_rd !== 32'h11AA3344) $display("[TB] FAIL lane_full got %h exp %h", dat_rd, 32'h11AA3344); else passed++;
  endtask

  task automatic test_same_cycle;
    drive(16'h0030, 4'hF, 32'h1, 4'h0);
    drive(16'h0030, 4'hF, 32'h2, 4'hF);
    total++; if (dat_rd !== 32'h1) $display("[TB] FAIL rbw_old got %h exp %h", dat_rd, 32'h1); else passed++;
    drive(16'h0030, 4'h0, 32'h0, 4'hF);
    total++; if (dat_rd !== 32'h2) $display("[TB] FAIL rbw_new got %h exp %h", dat_rd, 32'h2); else passed++;
  endtask

  task automatic test_back_to_back;
    drive(16'h0040, 4'hF, 32'h12345678, 4'h0);
    drive(16'h0043, 4'h0, 32'h0, 4'hF);
    total++; if (dat_rd !== 32'h12345678) $display("[TB] FAIL b2b_rd got %h exp %h", dat_rd, 32'h12345678); else passed++;
    drive(16'h0041, 4'h0, 32'h0, 4'b1001);
    total++; if (dat_rd !== 32'h12000078) $display("[TB] FAIL b2b_mask got %h exp %h", dat_rd, 32'h12000078); else passed++;
  endtask

  task automatic test_unmapped;
    drive(16'h0000, 4'hF, 32'hCAFEF00D, 4'h0);
    drive(16'h1000, 4'hF, 32'hBADBAD00, 4'h0);
    total++; if (err !== 1'b1) $display("[TB] FAIL unmap_wr_err got %b exp 1", err); else passed++;
    drive(16'h0000, 4'h0, 32'h0, 4'h0);
    total++; if (err !== 1'b0) $display("[TB] FAIL unmap_err_pulse got %b exp 0", err); else passed++;
    drive(16'h1000, 4'h0, 32'h0, 4'hF);
    total++; if (err !== 1'b1) $display("[TB] FAIL unmap_rd_err got %b exp 1", err); else passed++;
    total++; if (dat_rd !== 32'h0) $display("[TB] FAIL unmap_rd got %h exp 0", dat_rd); else passed++;
    drive(16'h0000, 4'h0, 32'h0, 4'hF);
    total++; if (dat_rd !== 32'hCAFEF00D) $display("[TB] FAIL unmap_no_alias got %h exp %h", dat_rd, 32'hCAFEF00D); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL word0_err got %b exp 0", err); else passed++;
    drive(16'h0FFC, 4'hF, 32'h55AA55AA, 4'h0);
    drive(16'h0FFC, 4'h0, 32'h0, 4'hF);
    total++; if (dat_rd !== 32'h55AA55AA) $display("[TB] FAIL last_word_rd got %h exp %h", dat_rd, 32'h55AA55AA); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL last_word_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_reset_mid_read;
    drive(16'h0010, 4'h0, 32'h0, 4'hF);
    total++; if (dat_rd !== 32'hDEADBEEF) $display("[TB] FAIL pre_rst_rd got %h exp %h", dat_rd, 32'hDEADBEEF); else passed++;
    rst = 1'b1;
    #1;
    total++; if (dat_rd !== 32'h0) $display("[TB] FAIL mid_rst_rd got %h exp 0", dat_rd); else passed++;
    #2;
    rst = 1'b0;
    drive(16'h1000, 4'h0, 32'h0, 4'hF);
    total++; if (err !== 1'b1) $display("[TB] FAIL pre_rst_err got %b exp 1", err); else passed++;
    rst = 1'b1;
    #1;
    total++; if (err !== 1'b0) $display("[TB] FAIL mid_rst_err got %b exp 0", err); else passed++;
    #2;
    rst = 1'b0;
    drive(16'h0010, 4'h0, 32'h0, 4'hF);
    total++; if (dat_rd !== 32'hDEADBEEF) $display("[TB] FAIL post_rst_keep got %h exp %h", dat_rd, 32'hDEADBEEF); else passed++;
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_mmio;
    logic [31:0] c1;
    logic [31:0] c2;
    drive(16'hFF00, 4'h0, 32'h0, 4'hF);
    c1 = dat_rd;
    repeat (4) drive(16'h0000, 4'h0, 32'h0, 4'h0);
    drive(16'hFF00, 4'h0, 32'h0, 4'hF);
    c2 = dat_rd;
    total++; if (c2 - c1 !== 32'd5) $display("[TB] FAIL cyc_delta got %0d exp 5", c2 - c1); else passed++;
    drive(16'hFF00, 4'hF, 32'hFFFFFFFF, 4'h0);
    total++; if (err !== 1'b0) $display("[TB] FAIL cyc_wr_err got %b exp 0", err); else passed++;
    drive(16'hFF04, 4'hF, 32'h0, 4'h0);
    total++; if (halt !== 1'b0) $display("[TB] FAIL halt_zero got %b exp 0", halt); else passed++;
    drive(16'hFF04, 4'hF, 32'h1, 4'h0);
    total++; if (halt !== 1'b1) $display("[TB] FAIL halt_set got %b exp 1", halt); else passed++;
    total++; if (tohost !== 32'h1) $display("[TB] FAIL tohost_one got %h exp 1", tohost); else passed++;
    drive(16'hFF04, 4'hF, 32'h0, 4'h0);
    total++; if (halt !== 1'b1) $display("[TB] FAIL halt_sticky got %b exp 1", halt); else passed++;
    total++; if (tohost !== 32'h0) $display("[TB] FAIL tohost_clr got %h exp 0", tohost); else passed++;
    drive(16'hFF08, 4'hF, 32'hA5A5A5A5, 4'h0);
    drive(16'hFF08, 4'b0001, 32'h0000003C, 4'h0);
    drive(16'hFF08, 4'h0, 32'h0, 4'b0011);
    total++; if (dat_rd !== 32'h0000A53C) $display("[TB] FAIL scratch_rd got %h exp %h", dat_rd, 32'h0000A53C); else passed++;
    drive(16'hFF0C, 4'h0, 32'h0, 4'hF);
    total++; if (err !== 1'b1) $display("[TB] FAIL resv_err got %b exp 1", err); else passed++;
    total++; if (dat_rd !== 32'h0) $display("[TB] FAIL resv_rd got %h exp 0", dat_rd); else passed++;
  endtask
`else
  task automatic test_no_mmio;
    drive(16'hFF04, 4'hF, 32'h1, 4'h0);
    total++; if (err !== 1'b1) $display("[TB] FAIL nommio_err got %b exp 1", err); else passed++;
    total++; if (halt !== 1'b0) $display("[TB] FAIL nommio_halt got %b exp 0", halt); else passed++;
    total++; if (tohost !== 32'h0) $display("[TB] FAIL nommio_tohost got %h exp 0", tohost); else passed++;
  endtask
`endif

  initial begin
    passed = 0;
    total  = 0;
    dat_a  = 16'h0;
    dat_we = 4'h0;
    dat_wd = 32'h0;
    dat_re = 4'h0;
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_same_cycle();
    test_back_to_back();
    test_unmapped();
    test_reset_mid_read();
`ifdef DMEM_MMIO_EN
    test_mmio();
`else
    test_no_mmio();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
